// File: rtl/prog_seq_pkg.sv
// prog_seq_pkg: shared state encoding, result record and defaults for the program launch sequencer
package prog_seq_pkg;
  typedef enum logic [2:0] {IDLE, ARM, RUN, NEXT, FINISH} state_t;
  localparam int DEF_TIMEOUT_CYC = 50000;
  // Widest cycle count a result record can carry; instances narrow it to CNT_W on read.
  localparam int MAX_CNT_W = 32;
  typedef struct packed {
    logic [MAX_CNT_W-1:0] cycles;
    logic                 timeout;
  } result_t;
endpackage

// File: rtl/prog_seq_timer.sv
// prog_seq_timer: saturating run-cycle counter with clear, enable and timeout compare
module prog_seq_timer
  import prog_seq_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             hit
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt;
  // count already includes the current cycle, so a completion this cycle can store it directly
  assign count = &cnt ? cnt : cnt + CNT_W'(1);
  assign hit   = count >= LIMIT;
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= count;
endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: launches enabled program slots in order on the core and records cycle counts and timeouts
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter  int NUM_PROGS   = 3,
  parameter  int ADDR_W      = 7,
  parameter  int CNT_W       = 16,
  parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int IW          = NUM_PROGS > 1 ? $clog2(NUM_PROGS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IW-1:0]     cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic              cfg_en,
  input  logic              go,
  output logic              start,
  output logic [ADDR_W-1:0] start_address,
  input  logic              done,
  output logic              busy,
  output logic              all_done,
  output logic              err,
  input  logic [IW-1:0]     rd_idx,
  output logic [CNT_W-1:0]  rd_cycles,
  output logic              rd_timeout
);
  state_t              state, nxt;
  logic [ADDR_W-1:0]   tbl_addr [NUM_PROGS];
  logic [NUM_PROGS-1:0] tbl_en;
  result_t             res [NUM_PROGS];
  result_t             rd_res;
  logic [IW-1:0]       idx, first_idx, nx_idx;
  logic                first_ok, nx_ok;
  logic [ADDR_W-1:0]   addr_q;
  logic                done_low, empty_q;
  logic                accept, done_ok, to_hit;
  logic [CNT_W-1:0]    count;
  logic                hit;

  prog_seq_timer #(.CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clock(clock),
    .reset(reset),
    .clr  (state == ARM),
    .en   (state == RUN),
    .count(count),
    .hit  (hit)
  );

  // Descending scan leaves the lowest qualifying slot in each result.
  always_comb begin
    first_ok  = 1'b0;
    first_idx = '0;
    nx_ok     = 1'b0;
    nx_idx    = '0;
    for (int i = NUM_PROGS - 1; i >= 0; i--) begin
      if (tbl_en[i]) begin
        first_ok  = 1'b1;
        first_idx = IW'(i);
      end
      if (tbl_en[i] && i > int'(idx)) begin
        nx_ok  = 1'b1;
        nx_idx = IW'(i);
      end
    end
  end

  assign accept  = state == IDLE && go;
  // A done still high from the previous program only counts after it has been seen low.
  assign done_ok = state == RUN && done && done_low;
  assign to_hit  = state == RUN && hit && !done_ok;

  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = accept && first_ok ? ARM : IDLE;
      ARM:     nxt = RUN;
      RUN:     nxt = done_ok || to_hit ? NEXT : RUN;
      NEXT:    nxt = nx_ok ? ARM : FINISH;
      FINISH:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    start         = state == ARM;
    busy          = state inside {ARM, RUN, NEXT};
    all_done      = state == FINISH || empty_q;
    start_address = start ? tbl_addr[idx] : addr_q;
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < NUM_PROGS; i++) tbl_addr[i] <= '0;
      tbl_en <= '0;
    end else if (cfg_we && int'(cfg_idx) < NUM_PROGS) begin
      tbl_addr[cfg_idx] <= cfg_addr;
      tbl_en[cfg_idx]   <= cfg_en;
    end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      idx      <= '0;
      addr_q   <= '0;
      done_low <= 1'b0;
      err      <= 1'b0;
      empty_q  <= 1'b0;
    end else begin
      empty_q <= accept && !first_ok;
      if (accept) begin
        err      <= 1'b0;
        done_low <= 1'b0;
        if (first_ok) idx <= first_idx;
      end
      if (state == ARM) addr_q <= tbl_addr[idx];
      if (state == FINISH) addr_q <= '0;
      if (state == RUN && !done) done_low <= 1'b1;
      if (state == NEXT) begin
        done_low <= 1'b0;
        if (nx_ok) idx <= nx_idx;
      end
      if (to_hit) err <= 1'b1;
    end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < NUM_PROGS; i++) res[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_PROGS; i++) res[i] <= '0;
    end else if (done_ok || to_hit) begin
      res[idx] <= '{cycles: MAX_CNT_W'(count), timeout: to_hit};
    end

  always_comb begin
    rd_res     = int'(rd_idx) < NUM_PROGS ? res[rd_idx] : '0;
    rd_cycles  = CNT_W'(rd_res.cycles);
    rd_timeout = rd_res.timeout;
  end
endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: scoreboard bench driving the sequencer against a scripted core model
module tb_prog_sequencer;
  localparam int AD = 256;
  localparam int TO = 1 << 16;

  logic        clock = 1'b0, reset = 1'b1;
  logic        cfg_we = 1'b0, cfg_en = 1'b0, go = 1'b0;
  logic [1:0]  cfg_idx = '0, rd_idx = '0;
  logic [6:0]  cfg_addr = '0;
  logic        start, busy, all_done, err, rd_timeout, done;
  logic [6:0]  start_address;
  logic [15:0] rd_cycles;

  int checks = 0, failures = 0;
  int exp_q[$], obs_q[$];
  logic wide, busy_bad;

  // Core model: done level as a function of cycles since the start pulse was taken.
  int   k = 0, cur_at = 0, cur_st = 0;
  int   dat[128], dst[128];
  logic pre_done = 1'b0;

  prog_sequencer #(.TIMEOUT_CYC(100)) dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_en(cfg_en), .go(go), .start(start), .start_address(start_address), .done(done),
    .busy(busy), .all_done(all_done), .err(err), .rd_idx(rd_idx), .rd_cycles(rd_cycles),
    .rd_timeout(rd_timeout)
  );

  always #5 clock = ~clock;

  always @(posedge clock or posedge reset)
    if (reset) k <= 0;
    else if (start) begin
      k      <= 1;
      cur_at <= dat[start_address];
      cur_st <= dst[start_address];
    end else if (k != 0 && k < 100000) k <= k + 1;

  assign done = (k == 0) ? pre_done : (k <= cur_st || (cur_at != 0 && k >= cur_at));

  function automatic int ev(input int a, input int n);
    return (a << 16) | n;
  endfunction

  task automatic do_reset();
    go = 1'b0; cfg_we = 1'b0; pre_done = 1'b0;
    for (int i = 0; i < 128; i++) begin dat[i] = 0; dst[i] = 0; end
    @(negedge clock); reset = 1'b1;
    @(negedge clock); @(negedge clock); reset = 1'b0;
  endtask

  task automatic cfg(input int i, input int a, input logic en);
    @(posedge clock); #1;
    cfg_we = 1'b1; cfg_idx = 2'(i); cfg_addr = 7'(a); cfg_en = en;
    @(posedge clock); #1;
    cfg_we = 1'b0;
  endtask

  // Pulses go (held through cycle `hold`), logs start/all_done events relative to the first ARM cycle.
  task automatic run_seq(input int budget, input int hold);
    int n, last;
    logic prev;
    n = 0; last = -1; prev = 1'b0; wide = 1'b0; busy_bad = 1'b0;
    @(posedge clock); #1 go = 1'b1;
    @(posedge clock);
    while (n < budget && !(n > hold && last >= 0 && !busy && n - last >= 4)) begin
      @(negedge clock);
      if (start) begin
        obs_q.push_back(ev(int'(start_address), n));
        if (prev) wide = 1'b1;
        if (!busy) busy_bad = 1'b1;
      end
      if (all_done) begin
        obs_q.push_back(ev(AD, n));
        last = n;
        if (busy) busy_bad = 1'b1;
      end
      prev = start;
      if (n == hold) go = 1'b0;
      n++;
    end
    go = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    checks++;
    if ({start, busy, all_done, err} !== 4'b0 || start_address !== 7'd0) begin
      failures++;
      $display("FAIL reset_outputs got start=%b busy=%b all_done=%b err=%b addr=%0h exp all 0",
               start, busy, all_done, err, start_address);
    end
    for (int i = 0; i < 3; i++) begin
      rd_idx = 2'(i); #1;
      checks++;
      if (int'({rd_timeout, rd_cycles}) !== 0) begin
        failures++;
        $display("FAIL reset_result[%0d] got=%0h exp=0", i, {rd_timeout, rd_cycles});
      end
    end
  endtask

  task automatic test_basic();
    int ec[3] = '{21, 0, 0};
    int e, o;
    do_reset();
    cfg(0, 7'h00, 1'b1);
    dat[7'h00] = 21;
    exp_q.push_back(ev(7'h00, 0));
    exp_q.push_back(ev(AD, 21 + 2));
    run_seq(100, 0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL basic_events got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL basic_event got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    checks++;
    if (wide || busy_bad || err !== 1'b0) begin
      failures++;
      $display("FAIL basic_handshake got wide=%b busy_bad=%b err=%b exp 0/0/0", wide, busy_bad, err);
    end
    for (int i = 0; i < 3; i++) begin
      rd_idx = 2'(i); #1; checks++;
      if (int'({rd_timeout, rd_cycles}) !== ec[i]) begin
        failures++; $display("FAIL basic_result[%0d] got=%0h exp=%0h", i, {rd_timeout, rd_cycles}, ec[i]);
      end
    end
  endtask

  task automatic test_three();
    int ec[3] = '{6, 11, 16};
    int a[3] = '{'h00, 'h20, 'h40};
    int t, e, o;
    do_reset();
    t = 0;
    for (int i = 0; i < 3; i++) begin
      cfg(i, a[i], 1'b1);
      dat[a[i]] = ec[i];
      exp_q.push_back(ev(a[i], t));
      t += ec[i] + 2;
    end
    exp_q.push_back(ev(AD, t));
    run_seq(200, 0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL three_events got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL three_event got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    checks++;
    if (wide || busy_bad || err !== 1'b0) begin
      failures++;
      $display("FAIL three_handshake got wide=%b busy_bad=%b err=%b exp 0/0/0", wide, busy_bad, err);
    end
    for (int i = 0; i < 3; i++) begin
      rd_idx = 2'(i); #1; checks++;
      if (int'({rd_timeout, rd_cycles}) !== ec[i]) begin
        failures++; $display("FAIL three_result[%0d] got=%0h exp=%0h", i, {rd_timeout, rd_cycles}, ec[i]);
      end
    end
  endtask

  task automatic test_stale();
    int e, o;
    do_reset();
    pre_done = 1'b1;
    cfg(0, 7'h10, 1'b1);
    dst[7'h10] = 3;
    dat[7'h10] = 8;
    exp_q.push_back(ev(7'h10, 0));
    exp_q.push_back(ev(AD, 8 + 2));
    run_seq(100, 0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL stale_events got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL stale_event got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    rd_idx = 2'd0; #1; checks++;
    if (int'({rd_timeout, rd_cycles}) !== 8) begin
      failures++; $display("FAIL stale_result got=%0h exp=8", {rd_timeout, rd_cycles});
    end
  endtask

  task automatic test_timeout();
    int ec[3] = '{10, TO + 100, 7};
    int a[3] = '{'h05, 'h15, 'h25};
    int r[3] = '{10, 100, 7};
    int t, e, o;
    do_reset();
    t = 0;
    for (int i = 0; i < 3; i++) begin
      cfg(i, a[i], 1'b1);
      dat[a[i]] = (i == 1) ? 0 : r[i];
      exp_q.push_back(ev(a[i], t));
      t += r[i] + 2;
    end
    exp_q.push_back(ev(AD, t));
    run_seq(400, 0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL timeout_events got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL timeout_event got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=1", err); end
    for (int i = 0; i < 3; i++) begin
      rd_idx = 2'(i); #1; checks++;
      if (int'({rd_timeout, rd_cycles}) !== ec[i]) begin
        failures++; $display("FAIL timeout_result[%0d] got=%0h exp=%0h", i, {rd_timeout, rd_cycles}, ec[i]);
      end
    end
  endtask

  // Runs straight after test_timeout so the new go must clear err and the old results.
  task automatic test_empty();
    int e, o;
    for (int i = 0; i < 3; i++) cfg(i, 7'h7F, 1'b0);
    exp_q.push_back(ev(AD, 0));
    run_seq(50, 0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL empty_events got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL empty_event got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    checks++;
    if (err !== 1'b0 || busy_bad) begin
      failures++; $display("FAIL empty_flags got err=%b busy_bad=%b exp 0/0", err, busy_bad);
    end
    for (int i = 0; i < 3; i++) begin
      rd_idx = 2'(i); #1; checks++;
      if (int'({rd_timeout, rd_cycles}) !== 0) begin
        failures++; $display("FAIL empty_result[%0d] got=%0h exp=0", i, {rd_timeout, rd_cycles});
      end
    end
  endtask

  task automatic test_skip();
    int ec[3] = '{0, 0, 4};
    int e, o;
    do_reset();
    cfg(0, 7'h11, 1'b0);
    cfg(1, 7'h22, 1'b0);
    cfg(2, 7'h33, 1'b1);
    dat[7'h11] = 3; dat[7'h22] = 3; dat[7'h33] = 4;
    exp_q.push_back(ev(7'h33, 0));
    exp_q.push_back(ev(AD, 4 + 2));
    run_seq(100, 0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL skip_events got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL skip_event got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 3; i++) begin
      rd_idx = 2'(i); #1; checks++;
      if (int'({rd_timeout, rd_cycles}) !== ec[i]) begin
        failures++; $display("FAIL skip_result[%0d] got=%0h exp=%0h", i, {rd_timeout, rd_cycles}, ec[i]);
      end
    end
  endtask

  task automatic test_done_wins();
    int e, o;
    do_reset();
    cfg(1, 7'h30, 1'b1);
    dat[7'h30] = 100;
    exp_q.push_back(ev(7'h30, 0));
    exp_q.push_back(ev(AD, 100 + 2));
    run_seq(200, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      o = obs_q.size() > 0 ? obs_q.pop_front() : -1;
      if (o !== e) begin failures++; $display("FAIL done_wins_event got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    rd_idx = 2'd1; #1; checks++;
    if (int'({rd_timeout, rd_cycles}) !== 100 || err !== 1'b0) begin
      failures++; $display("FAIL done_wins_result got=%0h err=%b exp=64 err=0", {rd_timeout, rd_cycles}, err);
    end
  endtask

  task automatic test_back_to_back();
    int e, o;
    do_reset();
    cfg(0, 7'h03, 1'b1);
    dat[7'h03] = 3;
    for (int s = 0; s < 3; s++) begin
      exp_q.push_back(ev(7'h03, s * 7));
      exp_q.push_back(ev(AD, s * 7 + 5));
    end
    run_seq(80, 15);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL b2b_events got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL b2b_event got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_run();
    int n, e, o;
    do_reset();
    cfg(0, 7'h0A, 1'b1);
    cfg(1, 7'h1A, 1'b1);
    dat[7'h0A] = 30; dat[7'h1A] = 40;
    @(posedge clock); #1 go = 1'b1;
    @(posedge clock); #1 go = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (!(start && start_address == 7'h1A) && n < 200);
    checks++;
    if (n !== 30 + 2 + 1) begin failures++; $display("FAIL midrun_second_start got=%0d exp=%0d", n, 33); end
    repeat (3) @(negedge clock);
    rd_idx = 2'd0; #1; checks++;
    if (busy !== 1'b1 || rd_cycles !== 16'd30) begin
      failures++; $display("FAIL midrun_before got busy=%b cyc=%0d exp 1/30", busy, rd_cycles);
    end
    #1 reset = 1'b1;
    #1; checks++;
    if ({start, busy, all_done, err} !== 4'b0 || start_address !== 7'd0 || rd_cycles !== 16'd0) begin
      failures++;
      $display("FAIL midrun_async got start=%b busy=%b all_done=%b err=%b addr=%0h cyc=%0d exp all 0",
               start, busy, all_done, err, start_address, rd_cycles);
    end
    @(negedge clock); reset = 1'b0;
    n = 0;
    repeat (8) begin @(negedge clock); if (start) n++; end
    checks++;
    if (n !== 0) begin failures++; $display("FAIL midrun_no_launch got=%0d starts exp=0", n); end
    cfg(0, 7'h0A, 1'b1);
    cfg(1, 7'h1A, 1'b1);
    exp_q.push_back(ev(7'h0A, 0));
    exp_q.push_back(ev(7'h1A, 30 + 2));
    exp_q.push_back(ev(AD, 30 + 2 + 40 + 2));
    run_seq(200, 0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL midrun_events got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL midrun_event got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_three();
    test_stale();
    test_timeout();
    test_empty();
    test_skip();
    test_done_wins();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Initiator side of the core launch handshake: drives `start`/`start_address` into the processor top and waits for its `done`.
- Launches a configurable list of programs back-to-back and records per-program cycle counts and timeouts.
- Replaces the hand-timed launch stimulus. Sits between the bench/host control and the core top level.

Parameters:
- NUM_PROGS, 3, number of program slots in the launch table.
- ADDR_W, 7, width of start_address (matches the core's start_address port).
- CNT_W, 16, width of the per-program cycle counter.
- TIMEOUT_CYC, 50000, RUN cycles allowed before a program is aborted as timed out.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cfg_we  input  1  write enable for the launch table.
- cfg_idx  input  $clog2(NUM_PROGS)  launch-table slot to write.
- cfg_addr  input  ADDR_W  start address stored into slot cfg_idx.
- cfg_en  input  1  slot-enable bit stored with cfg_addr.
- go  input  1  begin a sequence; sampled only in IDLE.
- start  output  1  one-cycle launch pulse to the core.
- start_address  output  ADDR_W  program entry address to the core.
- done  input  1  core completion level.
- busy  output  1  high from the go-accept cycle until FINISH.
- all_done  output  1  one-cycle pulse when the sequence completes.
- err  output  1  sticky; set if any program timed out this sequence.
- rd_idx  input  $clog2(NUM_PROGS)  result slot select.
- rd_cycles  output  CNT_W  combinational read of the cycle count for rd_idx.
- rd_timeout  output  1  combinational read of the timeout flag for rd_idx.

Behaviour:
- Reset values:
  - start=0, start_address=0, busy=0, all_done=0, err=0.
  - Table addresses=0, enables=0.
  - All result counts=0, all timeout flags=0.
  - State=IDLE, index=0.
- Reset asserted mid-sequence aborts immediately to these values. No launch is issued until a new go.
- Table writes:
  - Accepted in any state.
  - A write to the slot currently being run does not affect the running program. It takes effect on the next sequence.
- IDLE: go=1 -> clear err, all results and the done_low flag. Index=first enabled slot. Go to ARM. If no slot is enabled, pulse all_done the next cycle and stay IDLE; busy stays 0.
- ARM (exactly 1 cycle):
  - start=1 and start_address=table[index].
  - start_address holds its value through RUN. It returns to 0 only at FINISH.
  - Counter is cleared. Next state is RUN.
- RUN:
  - Counter increments every cycle, saturating at 2^CNT_W−1.
  - done_low is set the first cycle done=0 is sampled. This blanks a stale done held over from the previous program.
  - done=1 with done_low=1 -> store count into result[index] (count includes this cycle; minimum value 2). Go to NEXT.
  - Count reaches TIMEOUT_CYC first -> set result[index] timeout flag, set err, store TIMEOUT_CYC. Go to NEXT.
  - If done rises on the same cycle the timeout hits, done wins: no timeout flag is set.
- NEXT (1 cycle): clear done_low. Advance index to the next enabled slot. If one exists go to ARM, else go to FINISH. No wrap-around: slots run in ascending order exactly once.
- FINISH (1 cycle): all_done=1, busy→0, start_address→0. Next state is IDLE.
- go outside IDLE is ignored. go held high re-launches a fresh sequence from IDLE on the cycle after FINISH.
- Launch latency:
  - go sampled in IDLE → start high on the following cycle (ARM).
  - Program done → next program's start pulse 2 cycles later (NEXT, ARM).

Decomposition:
- Shared package prog_seq_pkg holds:
  - the state enum (IDLE, ARM, RUN, NEXT, FINISH);
  - the result record typedef (cycles, timeout);
  - the default TIMEOUT_CYC constant.
- One natural sub-module: prog_seq_timer, a saturating CNT_W counter with clear, enable and a timeout-compare output.
- Table and result storage stay in the top FSM.

Test Plan:
- Basic launch: slot0={0x00,en}, others disabled; go; core model raises done 20 cycles after start → start is a single 1-cycle pulse with start_address=0x00; rd_cycles[0]=21; all_done pulses once; err=0.
- Three programs: slots {0x00,0x20,0x40} all enabled; done after 5, 10, 15 cycles → three start pulses in address order, each 2 cycles after the previous done; results 6, 11, 16.
- Stale done: core holds done=1 through ARM and for 3 RUN cycles, drops it, then raises it 4 cycles later → no early completion; the completion is taken only on the second rising of done.
- Timeout: TIMEOUT_CYC=100; slot1's core never raises done → rd_timeout[1]=1, rd_cycles[1]=100, err=1; slot2 still launches and completes normally.
- Skip and empty table: only slot2 enabled → only address table[2] is launched. With all slots disabled, go → all_done pulses, start never asserted.
- Reset mid-RUN: assert reset during program 1 → all outputs reach reset values asynchronously; a new go restarts from the first enabled slot.
